// File: rtl/id_hazard_if.sv
// id_hazard_if: ID-stage hazard inputs and pipeline stall/flush controls
interface id_hazard_if #(parameter int CNT_W = 32);
    logic             id_valid;
    logic             branch_id;
    logic             jal_id;
    logic             jalr_id;
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             taken_id;
    logic             reg_write_ex;
    logic             mem_read_ex;
    logic [4:0]       rd_ex;
    logic             reg_write_mem;
    logic             mem_read_mem;
    logic [4:0]       rd_mem;
    logic             dmem_ready;
    logic             stall_pc;
    logic             stall_if_id;
    logic             bubble_id_ex;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             bubble_mem_wb;
    logic             flush_if_id;
    logic [CNT_W-1:0] dep_stall_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    modport master(
        output id_valid, branch_id, jal_id, jalr_id, rs1_id, rs2_id, taken_id,
               reg_write_ex, mem_read_ex, rd_ex, reg_write_mem, mem_read_mem, rd_mem, dmem_ready,
        input  stall_pc, stall_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem, bubble_mem_wb,
               flush_if_id, dep_stall_cnt, freeze_cnt
    );
    modport slave(
        input  id_valid, branch_id, jal_id, jalr_id, rs1_id, rs2_id, taken_id,
               reg_write_ex, mem_read_ex, rd_ex, reg_write_mem, mem_read_mem, rd_mem, dmem_ready,
        output stall_pc, stall_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem, bubble_mem_wb,
               flush_if_id, dep_stall_cnt, freeze_cnt
    );
endinterface

// File: rtl/id_hazard_sequencer.sv
// id_hazard_sequencer: bubble/freeze/flush sequencing for ID-stage branch resolution
module id_hazard_sequencer #(parameter int CNT_W = 32) (
    input  logic      clk,
    input  logic      rst_n,
    id_hazard_if.slave bus
);
    typedef enum logic [1:0] {RUN, DEP, MEMW} state_t;
    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n, n1, n2, n;
    logic             use1, use2, freeze, dep, frz;
    logic [CNT_W-1:0] dep_q, frz_q;
    always_comb begin
        use1 = bus.id_valid & (bus.branch_id | bus.jalr_id) & (bus.rs1_id != 5'd0);
        use2 = bus.id_valid & bus.branch_id & (bus.rs2_id != 5'd0);
        // load data never reaches the ID forwarding path, so a MEM load costs a bubble
        n1 = !use1 ? 2'd0 :
             (bus.reg_write_ex & (bus.rd_ex == bus.rs1_id)) ? (bus.mem_read_ex ? 2'd2 : 2'd1) :
             (bus.reg_write_mem & bus.mem_read_mem & (bus.rd_mem == bus.rs1_id)) ? 2'd1 : 2'd0;
        n2 = !use2 ? 2'd0 :
             (bus.reg_write_ex & (bus.rd_ex == bus.rs2_id)) ? (bus.mem_read_ex ? 2'd2 : 2'd1) :
             (bus.reg_write_mem & bus.mem_read_mem & (bus.rd_mem == bus.rs2_id)) ? 2'd1 : 2'd0;
        n = (n1 > n2) ? n1 : n2;
        freeze = bus.mem_read_mem & !bus.dmem_ready;
        state_n = state;
        cnt_n = cnt;
        dep = 1'b0;
        case (state)
            RUN: begin
                if (freeze) state_n = MEMW;
                else if (n != 2'd0) begin
                    dep = 1'b1;
                    cnt_n = n - 2'd1;
                    state_n = (n == 2'd2) ? DEP : RUN;
                end
            end
            DEP: begin
                if (freeze) state_n = MEMW;
                else begin
                    dep = 1'b1;
                    cnt_n = cnt - 2'd1;
                    state_n = (cnt <= 2'd1) ? RUN : DEP;
                end
            end
            MEMW: if (bus.dmem_ready) state_n = (cnt != 2'd0) ? DEP : RUN;
            default: state_n = RUN;
        endcase
        dep = dep & rst_n;
        frz = freeze & rst_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
            dep_q <= '0;
            frz_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dep_q <= dep_q + CNT_W'(dep);
            frz_q <= frz_q + CNT_W'(frz);
        end
    end
    assign bus.stall_pc      = dep | frz;
    assign bus.stall_if_id   = dep | frz;
    assign bus.bubble_id_ex  = dep;
    assign bus.stall_id_ex   = frz;
    assign bus.stall_ex_mem  = frz;
    assign bus.bubble_mem_wb = frz;
    assign bus.flush_if_id   = rst_n & !dep & !frz & bus.id_valid &
                               (bus.jal_id | bus.jalr_id | (bus.branch_id & bus.taken_id));
    assign bus.dep_stall_cnt = dep_q;
    assign bus.freeze_cnt    = frz_q;
endmodule

// File: tb/tb_id_hazard_sequencer.sv
// tb_id_hazard_sequencer: directed checks of bubble counts, freeze, flush gating and reset
module tb_id_hazard_sequencer;
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] DEPS = 7'b1110000;
    localparam logic [6:0] FRZ  = 7'b1101110;
    localparam logic [6:0] FL   = 7'b0000001;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] o;
    id_hazard_if #(.CNT_W(32)) bus();
    id_hazard_sequencer #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign o = {bus.stall_pc, bus.stall_if_id, bus.bubble_id_ex, bus.stall_id_ex,
                bus.stall_ex_mem, bus.bubble_mem_wb, bus.flush_if_id};
    task automatic chk_out(input logic [6:0] exp, input string tag);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: outputs got %b expected %b", tag, o, exp);
        end
    endtask
    task automatic chk_cnt(input int d, input int f, input string tag);
        checks++;
        assert (bus.dep_stall_cnt === 32'(d) && bus.freeze_cnt === 32'(f)) else begin
            errors++;
            $error("FAIL %s: counters got dep=%0d frz=%0d expected dep=%0d frz=%0d",
                   tag, bus.dep_stall_cnt, bus.freeze_cnt, d, f);
        end
    endtask
    task automatic step(input logic [6:0] exp, input string tag);
        #1 chk_out(exp, tag);
        @(negedge clk);
    endtask
    task automatic idle();
        bus.id_valid = 0; bus.branch_id = 0; bus.jal_id = 0; bus.jalr_id = 0;
        bus.rs1_id = 0; bus.rs2_id = 0; bus.taken_id = 0;
        bus.reg_write_ex = 0; bus.mem_read_ex = 0; bus.rd_ex = 0;
        bus.reg_write_mem = 0; bus.mem_read_mem = 0; bus.rd_mem = 0; bus.dmem_ready = 1;
    endtask
    task automatic beq56(input logic taken);
        bus.id_valid = 1; bus.branch_id = 1; bus.rs1_id = 5; bus.rs2_id = 6; bus.taken_id = taken;
    endtask
    initial begin
        idle();
        beq56(1);
        bus.reg_write_ex = 1; bus.mem_read_ex = 1; bus.rd_ex = 5;
        @(negedge clk);
        chk_out(IDLE, "reset_out");
        chk_cnt(0, 0, "reset_cnt");
        idle();
        rst_n = 1;
        // load in EX feeding a taken beq: two bubbles, then the redirect
        beq56(1);
        bus.reg_write_ex = 1; bus.mem_read_ex = 1; bus.rd_ex = 5;
        step(DEPS, "lu_b1");
        step(DEPS, "lu_b2");
        bus.reg_write_ex = 0; bus.mem_read_ex = 0;
        step(FL, "lu_res");
        chk_cnt(2, 0, "lu_cnt");
        // ALU result in EX feeding jalr
        idle();
        bus.id_valid = 1; bus.jalr_id = 1; bus.rs1_id = 7; bus.reg_write_ex = 1; bus.rd_ex = 7;
        step(DEPS, "alu_b1");
        bus.reg_write_ex = 0;
        step(FL, "alu_res");
        bus.reg_write_ex = 1; bus.rs1_id = 0;
        step(FL, "alu_x0");
        bus.rs1_id = 3; bus.rs2_id = 7;
        step(FL, "jalr_rs2");
        chk_cnt(3, 0, "alu_cnt");
        // MEM-stage ALU result is forwarded; MEM-stage load is not
        idle();
        bus.id_valid = 1; bus.branch_id = 1; bus.rs1_id = 3; bus.rs2_id = 0;
        bus.reg_write_mem = 1; bus.rd_mem = 3;
        step(IDLE, "memfwd");
        bus.mem_read_mem = 1;
        step(DEPS, "memld");
        bus.id_valid = 0;
        step(IDLE, "novalid");
        bus.id_valid = 1; bus.reg_write_mem = 0; bus.mem_read_mem = 0;
        step(IDLE, "memld_res");
        chk_cnt(4, 0, "mem_cnt");
        // freeze arriving between the two load-use bubbles
        idle();
        beq56(0);
        bus.reg_write_ex = 1; bus.mem_read_ex = 1; bus.rd_ex = 5;
        step(DEPS, "fz_b1");
        bus.reg_write_mem = 1; bus.mem_read_mem = 1; bus.rd_mem = 9; bus.dmem_ready = 0;
        step(FRZ, "fz_f1");
        step(FRZ, "fz_f2");
        step(FRZ, "fz_f3");
        bus.dmem_ready = 1;
        step(IDLE, "fz_exit");
        step(DEPS, "fz_b2");
        idle();
        step(IDLE, "fz_done");
        chk_cnt(6, 3, "fz_cnt");
        // freeze and EX dependency in the same cycle
        idle();
        bus.id_valid = 1; bus.branch_id = 1; bus.rs1_id = 7; bus.reg_write_ex = 1; bus.rd_ex = 7;
        bus.reg_write_mem = 1; bus.mem_read_mem = 1; bus.rd_mem = 9; bus.dmem_ready = 0;
        step(FRZ, "fvd_f");
        bus.dmem_ready = 1;
        step(IDLE, "fvd_exit");
        bus.mem_read_mem = 0; bus.reg_write_mem = 0;
        step(DEPS, "fvd_dep");
        bus.reg_write_ex = 0;
        step(IDLE, "fvd_done");
        chk_cnt(7, 4, "fvd_cnt");
        // asynchronous reset while in DEP with one bubble left
        idle();
        beq56(0);
        bus.reg_write_ex = 1; bus.mem_read_ex = 1; bus.rd_ex = 5;
        step(DEPS, "rs_b1");
        #1 chk_out(DEPS, "rs_dep");
        #1 rst_n = 0;
        #1 chk_out(IDLE, "rs_async");
        chk_cnt(0, 0, "rs_cnt");
        @(negedge clk);
        idle();
        rst_n = 1;
        step(IDLE, "rs_post1");
        step(IDLE, "rs_post2");
        chk_cnt(0, 0, "rs_cnt2");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
